layer4_flatten_buffer: RTL and testbench
========================================

# layer4_flatten_buffer

Collects the parallel per-channel outputs of the layer-3 max-pool stage, one spatial position per pool `ready` pulse, into an on-chip frame buffer. Once a full frame is captured, it serialises the frame channel-major, one word per handshake, to the layer-4 fully-connected engine. It sits directly downstream of the layer-3 pooling array and decouples its free-running output from the FC stage's backpressure.

## Interface
- `bits`, 16: word width, signed two's complement
- `bits_shift`, 4: log2 of the lane stride in `data_in`; the stride must be at least `bits`
- `channel_num`, 16: number of parallel channels in `data_in`
- `positions`, 16: pooled positions per channel per frame, for example 4x4
- `clk_in` input 1: clock; every register is rising-edge
- `rst` input 1: asynchronous, active-high reset
- `data_in` input `channel_num<<bits_shift`: one word per channel; lane i occupies bits `[(i<<bits_shift)+bits-1 : i<<bits_shift]`
- `in_valid` input 1: single-cycle strobe for one position; it is the pool `ready`
- `start` input 1: frame-start pulse
- `data_out` output `bits`: serialised word
- `out_valid` output 1: `data_out` is valid
- `out_ready` input 1: downstream accepts the word
- `out_last` output 1: asserted with the final word of the frame
- `done` output 1: one-cycle pulse after the last word is accepted
- `overflow` output 1: sticky error flag; cleared only by `rst` or by `start` in IDLE

## Operation
- States are IDLE, FILL and DRAIN, with a 2-bit state encoding.
- **IDLE**
  - `in_valid` is ignored.
  - `start` clears the write counter `wp` and `overflow`, then goes to FILL.
- **FILL**
  - Each `in_valid` writes `data_in` to `mem[wp]` and increments `wp`.
  - When a write lands at `wp == positions-1`, the state goes to DRAIN and the read index `rp` is cleared.
  - `start` in FILL clears `wp` and restarts the frame. Data already written is discarded and `overflow` is unchanged.
  - If `start` and `in_valid` occur in the same cycle, `start` wins and the `in_valid` word is written at index 0 with `wp` set to 1.
- **DRAIN**
  - Read order is `rp = c*positions + p` for c from 0 to `channel_num-1` and p from 0 to `positions-1`.
  - The word read is lane c of `mem[p]`.
  - The output register loads the word for `rp` when it is empty, or when the current word is accepted with `out_valid && out_ready`.
  - `out_last` is set when `rp == channel_num*positions-1`.
  - Acceptance of the last word: drop `out_valid`, pulse `done` on the next cycle, return to IDLE.
  - `in_valid` in DRAIN drops the data and sets `overflow`.
  - `start` in DRAIN is ignored and does not set `overflow`.
- `rp` width is `$clog2(channel_num*positions)`; `wp` width is `$clog2(positions)`. Neither counter wraps: each is cleared on the state transition.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `done` and `overflow` are 0.
  - `data_out` is 0 and the state is IDLE.
  - The buffer contents are not reset.
- Reset mid-frame aborts the frame immediately, asynchronously, with no `done` pulse.
- `in_valid` on cycle t writes `mem[wp]` at edge t.
- First-word latency: the last FILL write occurs at edge t, and `out_valid` rises after edge t+1.
- Throughput is one word per cycle while `out_ready` is held at 1. A frame takes `channel_num*positions` cycles plus 1 cycle of latency.
- Handshake rules:
  - `data_out` and `out_last` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without acceptance except on `rst`.
- `done` is high for exactly one cycle, following the edge that accepted the `out_last` word.

## Configuration
- Macro: `LAYER4_FLATTEN_RELU_EN`.
- Defined: each serialised word passes through ReLU, so a negative value (MSB set) outputs 0. The ReLU is applied before the output register, with no added latency.
- Undefined: words pass through unmodified.
- Buffer contents are raw in both cases.

## Structure
- Package `layer4_pkg` holds:
  - the state enum (IDLE, FILL, DRAIN);
  - the default constants `BITS`, `CHANNEL_NUM`, `POSITIONS`;
  - the derived `FRAME_WORDS = CHANNEL_NUM*POSITIONS`.
- Sub-module `flatten_store`:
  - a `positions`-deep register array, `channel_num<<bits_shift` wide;
  - one synchronous write port;
  - an asynchronous read by `p` with lane select by `c`.
- The FSM, counters and output register live in the top module.

## Test plan
- **Basic frame:** `start`, then 16 `in_valid` pulses, with lane i at position p = `i*16+p`, and `out_ready` held at 1 -> 256 words 0,1,…,255 in order. `out_last` is asserted with word 255 and `done` pulses once.
- **Backpressure:** toggle `out_ready` 1,0,0,1 repeating -> words stay stable while stalled, with no loss or duplication, and the sequence still reads 0..255.
- **Overflow:** one `in_valid` during DRAIN with `data_in` all ones -> `overflow` rises to 1 and stays 1. The drained data is unchanged and `overflow` clears at the next `start`.
- **Restart:** `start` after 5 writes in FILL, followed by a simultaneous `start` and `in_valid` -> the frame restarts. The first serialised word comes from that write and the count needs 15 more writes.
- **Reset:** `rst` asserted mid-DRAIN, after word 100 -> outputs go to 0 asynchronously with no `done`. A new frame then runs normally.
- **ReLU:** with `LAYER4_FLATTEN_RELU_EN` defined, lane value 16'hFFF0 outputs 0 and 16'h0010 outputs 16'h0010. With the macro undefined, 16'hFFF0 passes unchanged.

Source files
------------

// File: rtl/layer4_pkg.sv
// layer4_pkg: shared state encoding and default sizing for the layer-4 flatten buffer
package layer4_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;
    localparam int BITS        = 16;
    localparam int BITS_SHIFT  = 4;
    localparam int CHANNEL_NUM = 16;
    localparam int POSITIONS   = 16;
    localparam int FRAME_WORDS = CHANNEL_NUM * POSITIONS;
endpackage

// File: rtl/layer4_flatten_buffer_store.sv
// flatten_store: frame buffer, one row of all channel lanes per pooled position
//   clk_in  : write clock
//   i_we    : write enable, i_waddr/i_wdata : row index and full row of lanes
//   i_rd_p  : row (position) to read, i_rd_c : lane (channel) within that row
//   o_rdata : selected lane, combinational read
module flatten_store
    import layer4_pkg::*;
#(
    parameter int bits        = BITS,
    parameter int bits_shift  = BITS_SHIFT,
    parameter int channel_num = CHANNEL_NUM,
    parameter int positions   = POSITIONS,
    parameter int WPW         = (positions > 1) ? $clog2(positions) : 1,
    parameter int CW          = (channel_num > 1) ? $clog2(channel_num) : 1
) (
    input  logic                                clk_in,
    input  logic                                i_we,
    input  logic [WPW-1:0]                      i_waddr,
    input  logic [(channel_num<<bits_shift)-1:0] i_wdata,
    input  logic [WPW-1:0]                      i_rd_p,
    input  logic [CW-1:0]                       i_rd_c,
    output logic [bits-1:0]                     o_rdata
);
    logic [(channel_num<<bits_shift)-1:0] r_mem [positions];
    always_ff @(posedge clk_in)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_rd_p][(int'(i_rd_c) << bits_shift) +: bits];
endmodule

// File: rtl/layer4_flatten_buffer.sv
// layer4_flatten_buffer: captures one pooled frame, then streams it channel-major with valid/ready
//   clk_in, rst (async, active-high)
//   data_in/in_valid : one position of all channel lanes per strobe; start : frame start
//   data_out/out_valid/out_ready/out_last : serialised output handshake
//   done : one-cycle pulse after the last word is accepted; overflow : sticky write-in-DRAIN flag
//   LAYER4_FLATTEN_RELU_EN : when defined, negative output words are clamped to zero
module layer4_flatten_buffer
    import layer4_pkg::*;
#(
    parameter int bits        = BITS,
    parameter int bits_shift  = BITS_SHIFT,
    parameter int channel_num = CHANNEL_NUM,
    parameter int positions   = POSITIONS
) (
    input  logic                                clk_in,
    input  logic                                rst,
    input  logic [(channel_num<<bits_shift)-1:0] data_in,
    input  logic                                in_valid,
    input  logic                                start,
    output logic [bits-1:0]                     data_out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                done,
    output logic                                overflow
);
    localparam int FRAME = channel_num * positions;
    localparam int RPW   = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int WPW   = (positions > 1) ? $clog2(positions) : 1;
    localparam int CW    = (channel_num > 1) ? $clog2(channel_num) : 1;
    state_t           r_state, w_next;
    logic [WPW-1:0]   r_wp, w_waddr, w_rd_p;
    logic [RPW-1:0]   r_rp;
    logic [CW-1:0]    w_rd_c;
    logic             r_issued;
    logic             w_we, w_last_fill, w_accept, w_load, w_rp_end;
    logic [bits-1:0]  w_lane, w_word;
    // start in FILL wins over a same-cycle in_valid and redirects that write to row 0
    assign w_waddr     = (r_state == FILL && start) ? '0 : r_wp;
    assign w_we        = r_state == FILL && in_valid;
    assign w_last_fill = w_we && w_waddr == WPW'(positions - 1);
    assign w_accept    = out_valid && out_ready;
    // r_issued marks that the final word has already been loaded, so nothing more is fetched
    assign w_load      = r_state == DRAIN && !r_issued && (!out_valid || out_ready);
    assign w_rp_end    = r_rp == RPW'(FRAME - 1);
    assign w_rd_p      = WPW'(r_rp % positions);
    assign w_rd_c      = CW'(r_rp / positions);
`ifdef LAYER4_FLATTEN_RELU_EN
    assign w_word = w_lane[bits-1] ? '0 : w_lane;
`else
    assign w_word = w_lane;
`endif
    flatten_store #(
        .bits(bits), .bits_shift(bits_shift), .channel_num(channel_num),
        .positions(positions), .WPW(WPW), .CW(CW)
    ) u_store (
        .clk_in(clk_in), .i_we(w_we), .i_waddr(w_waddr), .i_wdata(data_in),
        .i_rd_p(w_rd_p), .i_rd_c(w_rd_c), .o_rdata(w_lane)
    );
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && start)                   ? FILL  :
                 w_last_fill                                  ? DRAIN :
                 (r_state == DRAIN && w_accept && out_last)   ? IDLE  : r_state;
    end
    always_ff @(posedge clk_in or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_issued  <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= r_state == DRAIN && w_accept && out_last;
            if (r_state == IDLE && start) begin
                r_wp     <= '0;
                overflow <= 1'b0;
            end
            if (w_we) r_wp <= w_last_fill ? '0 : w_waddr + 1'b1;
            else if (r_state == FILL && start) r_wp <= '0;
            if (w_last_fill) begin
                r_rp     <= '0;
                r_issued <= 1'b0;
            end
            if (r_state == DRAIN && in_valid) overflow <= 1'b1;
            if (w_load) begin
                data_out  <= w_word;
                out_valid <= 1'b1;
                out_last  <= w_rp_end;
                r_issued  <= w_rp_end;
                r_rp      <= w_rp_end ? r_rp : r_rp + 1'b1;
            end else if (w_accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_layer4_flatten_buffer.sv
// tb_layer4_flatten_buffer: directed frames with a scoreboard queue checked by a handshake monitor
module tb_layer4_flatten_buffer;
    logic         clk_in = 1'b0, rst = 1'b1, in_valid = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [255:0] data_in = '0;
    logic [15:0]  data_out;
    logic         out_valid, out_last, done, overflow;
    int           checks = 0, errors = 0, acc_cnt = 0, done_cnt = 0, k = 0;
    bit           bp = 1'b0, prev_stall = 1'b0, prev_acc_last = 1'b0;
    logic [15:0]  prev_data;
    logic         prev_last;
    logic [15:0]  vals [16][16];
    logic [16:0]  q [$];

    layer4_flatten_buffer dut (
        .clk_in(clk_in), .rst(rst), .data_in(data_in), .in_valid(in_valid), .start(start),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef LAYER4_FLATTEN_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [255:0] pos(input int p);
        logic [255:0] d;
        for (int i = 0; i < 16; i++) d[i*16 +: 16] = vals[i][p];
        return d;
    endfunction

    // out_ready pattern 1,0,0,1 while bp is set, otherwise held high
    initial forever begin
        @(posedge clk_in);
        #1;
        out_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
        k++;
    end

    always @(negedge clk_in) begin
        if (rst) begin
            prev_stall    = 1'b0;
            prev_acc_last = 1'b0;
        end else begin
            if (prev_acc_last || done) chk("done_pulse", done, prev_acc_last);
            if (prev_stall) chk("stall_stable", {out_valid, out_last, data_out}, {1'b1, prev_last, prev_data});
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_word", {out_last, data_out}, 17'h1ffff);
                else chk("word", {out_last, data_out}, q.pop_front());
                acc_cnt++;
            end
            if (done) done_cnt++;
            prev_stall    = out_valid && !out_ready;
            prev_data     = data_out;
            prev_last     = out_last;
            prev_acc_last = out_valid && out_ready && out_last;
        end
    end

    task automatic step(input logic st, input logic iv, input logic [255:0] d);
        @(posedge clk_in);
        #1;
        start = st;
        in_valid = iv;
        data_in = d;
    endtask

    task automatic build(input int tag);
        for (int c = 0; c < 16; c++)
            for (int p = 0; p < 16; p++)
                vals[c][p] = 16'((tag == 1 ? 32'h1000 : 32'h0) + c * 16 + p);
        if (tag == 2) begin
            vals[0][0] = 16'hFFF0;
            vals[0][1] = 16'h0010;
        end
        for (int c = 0; c < 16; c++)
            for (int p = 0; p < 16; p++)
                q.push_back({(c == 15 && p == 15), relu(vals[c][p])});
    endtask

    task automatic latency();
        @(posedge clk_in);
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        chk("latency_t", out_valid, 1'b0);
        @(posedge clk_in);
        #1;
        chk("latency_t1", out_valid, 1'b1);
        chk("first_word", data_out, relu(vals[0][0]));
    endtask

    task automatic run_fill();
        step(1'b1, 1'b0, '0);
        for (int p = 0; p < 16; p++) step(1'b0, 1'b1, pos(p));
        latency();
    endtask

    task automatic wait_done();
        int n0 = done_cnt;
        int t = 0;
        while (done_cnt == n0 && t < 3000) begin
            @(posedge clk_in);
            t++;
        end
        if (t >= 3000) chk("done_timeout", 1'b0, 1'b1);
        repeat (3) @(posedge clk_in);
        #1;
        chk("done_count", done_cnt, n0 + 1);
        chk("queue_empty", q.size(), 0);
        chk("idle_valid", out_valid, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_data", data_out, 16'h0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        // basic frame
        build(0);
        run_fill();
        wait_done();
        chk("basic_overflow", overflow, 1'b0);
        // backpressure
        bp = 1'b1;
        build(0);
        run_fill();
        wait_done();
        bp = 1'b0;
        // overflow during drain, start ignored in drain
        build(0);
        run_fill();
        repeat (10) @(posedge clk_in);
        step(1'b0, 1'b1, '1);
        step(1'b0, 1'b0, '0);
        chk("overflow_set", overflow, 1'b1);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("overflow_start_drain", overflow, 1'b1);
        wait_done();
        chk("overflow_sticky", overflow, 1'b1);
        // restart in fill, start and in_valid together
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("overflow_cleared", overflow, 1'b0);
        for (int p = 0; p < 5; p++) step(1'b0, 1'b1, {16{16'hDEAD}});
        build(1);
        step(1'b1, 1'b1, pos(0));
        for (int p = 1; p < 16; p++) step(1'b0, 1'b1, pos(p));
        latency();
        wait_done();
        // asynchronous reset mid-drain after word 100
        begin
            int a0 = acc_cnt;
            int t = 0;
            int n0;
            build(0);
            run_fill();
            while (acc_cnt < a0 + 101 && t < 1000) begin
                @(posedge clk_in);
                t++;
            end
            if (t >= 1000) chk("reset_wait_timeout", 1'b0, 1'b1);
            #2;
            rst = 1'b1;
            #1;
            chk("arst_valid", out_valid, 1'b0);
            chk("arst_last", out_last, 1'b0);
            chk("arst_data", data_out, 16'h0);
            chk("arst_done", done, 1'b0);
            q.delete();
            n0 = done_cnt;
            @(posedge clk_in);
            #1;
            rst = 1'b0;
            repeat (5) @(posedge clk_in);
            #1;
            chk("arst_no_done", done_cnt, n0);
        end
        build(0);
        run_fill();
        wait_done();
        // ReLU frame
        build(2);
        run_fill();
        wait_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
